ctrl: RTL and testbench
=======================

CTRL -- requirements
Module: ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings SHALL be fixed constants.
REQ-002 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 op  input  7  instruction opcode field, instr[6:0].
REQ-006 funct3  input  3  instr[14:12].
REQ-007 funct7  input  1  instr[30], i.e. funct7 bit 5.
REQ-008 Zero  input  1  ALU result-equals-zero flag.
REQ-009 PCSrc  output  1  1 selects the branch/jump target as next PC.
REQ-010 MemWrite  output  1  data-memory write enable.
REQ-011 ALUSrc  output  1  1 selects the immediate as ALU operand B.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-014 ResultSrc  output  2  write-back select: 00 ALU, 01 memory, 10 PC+4.
REQ-015 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 Illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-017 All outputs except Illegal SHALL be combinational in op, funct3, funct7, Zero and rst, with zero cycles of latency.
REQ-018 Each opcode SHALL decode to the fields below; Branch, Jump and ALUOp are internal.
- lw 0000011: RegWrite 1, ImmSrc 00, ALUSrc 1, MemWrite 0, ResultSrc 01, Branch 0, Jump 0, ALUOp 00.
- sw 0100011: RegWrite 0, ImmSrc 01, ALUSrc 1, MemWrite 1, ResultSrc 00, Branch 0, Jump 0, ALUOp 00.
- R-type 0110011: RegWrite 1, ImmSrc 00, ALUSrc 0, MemWrite 0, ResultSrc 00, Branch 0, Jump 0, ALUOp 10.
- beq 1100011: RegWrite 0, ImmSrc 10, ALUSrc 0, MemWrite 0, ResultSrc 00, Branch 1, Jump 0, ALUOp 01.
- I-type ALU 0010011: RegWrite 1, ImmSrc 00, ALUSrc 1, MemWrite 0, ResultSrc 00, Branch 0, Jump 0, ALUOp 10.
- jal 1101111: RegWrite 1, ImmSrc 11, ALUSrc 0, MemWrite 0, ResultSrc 10, Branch 0, Jump 1, ALUOp 00.
REQ-019 Any other opcode SHALL drive every output field and ALUOp to 0, so that no register write, memory write or PC redirect occurs.
REQ-020 PCSrc SHALL equal (Branch AND Zero) OR Jump.
REQ-021 ALUOp 00 SHALL give ALUControl 000, and ALUOp 01 SHALL give ALUControl 001.
REQ-022 With ALUOp 10, ALUControl SHALL be decoded from funct3:
- 000: 001 (sub) when op[5]=1 and funct7=1; otherwise 000 (add). addi is therefore never decoded as subtract.
- 010: 101 (slt).
- 110: 011 (or).
- 111: 010 (and).
- any other funct3: 000.
REQ-023 ALUOp 11 SHALL give ALUControl 000.

Reset
REQ-024 While rst=1, RegWrite, MemWrite and PCSrc SHALL be forced to 0; all other decode outputs SHALL follow op unchanged.
REQ-025 Illegal SHALL be 0 on the clock edge following rst=1.
REQ-026 Illegal SHALL be 0 until the first illegal opcode is sampled after reset.
REQ-027 If rst=1 and an illegal op are present on the same edge, reset SHALL win.

Configuration
REQ-028 With macro CTRL_ILLEGAL_EN defined, Illegal SHALL be set on any rising clk edge where rst=0 and op is not one of the six supported opcodes.
REQ-029 Once set, Illegal SHALL remain 1 until reset.
REQ-030 Without CTRL_ILLEGAL_EN, Illegal SHALL be tied to 0 and no flop SHALL be inferred; the port SHALL remain present.

Structure
REQ-031 A shared package ctrl_pkg SHALL hold:
- the opcode constants;
- the ImmSrc, ResultSrc and ALUOp encodings;
- the ALUControl operation encodings.
REQ-032 The ALU-control decode SHALL be a sub-module alu_dec, with inputs opb5, funct3, funct7 and ALUOp, and output ALUControl.
REQ-033 The main decoder and the PCSrc logic SHALL be inside ctrl itself.

Verification
REQ-034 op=0000011, Zero=0, rst=0 -> RegWrite 1, ImmSrc 00, ALUSrc 1, MemWrite 0, ResultSrc 01, PCSrc 0, ALUControl 000.
REQ-035 op=0100011 -> RegWrite 0, ImmSrc 01, ALUSrc 1, MemWrite 1, PCSrc 0, ALUControl 000.
REQ-036 op=1100011 with Zero=1 -> PCSrc 1, ImmSrc 10, ALUSrc 0, ALUControl 001; the same op with Zero=0 -> PCSrc 0.
REQ-037 op=1101111 -> RegWrite 1, ImmSrc 11, MemWrite 0, ResultSrc 10, PCSrc 1.
REQ-038 ALU-control cases:
- op=0010011, funct3=000, funct7=1 -> ALUControl 000, ResultSrc 00.
- op=0110011, funct3=000, funct7=1 -> ALUControl 001.
- op=0110011, funct3=111 -> ALUControl 010.
- op=0110011, funct3=110 -> ALUControl 011.
- op=0110011, funct3=010 -> ALUControl 101.
REQ-039 With CTRL_ILLEGAL_EN defined:
- op=1111111 for one edge -> Illegal 1, held after op returns to 0000011.
- rst=1 for one edge -> Illegal 0.
- op=1111111 with rst=1 -> Illegal stays 0, and RegWrite, MemWrite, PCSrc are all 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the single-cycle RV32 control decoder: opcodes, mux selects, ALU ops.
// Latency: n/a (constants only). Backpressure: n/a.
// Holds a legality helper used by the sticky illegal-opcode flag.
package ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_LW)    || (op == OP_SW)    || (op == OP_RTYPE) ||
               (op == OP_BEQ)   || (op == OP_ITYPE) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU operation decode from ALUOp, funct3 and funct7 / opcode bit 5.
// Latency: combinational, zero cycles. Backpressure: none.
// Subtract only for R-type funct3=000 with funct7 set; addi never subtracts.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (opb5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/ctrl.sv
// Single-cycle RV32 control unit: main decode, PC select, sticky Illegal flag (macro CTRL_ILLEGAL_EN).
// Latency: decode outputs combinational; Illegal registered on clk. Backpressure: none.
// Reset masks RegWrite/MemWrite/PCSrc so nothing architectural changes while rst is high.
module ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCSrc,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;

    always_comb begin
        reg_write = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_op    = ALUOP_ADD;
        ALUSrc    = 1'b0;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALU;
        case (op)
            OP_LW: begin
                reg_write = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = RES_MEM;
            end
            OP_SW: begin
                ImmSrc    = IMM_S;
                ALUSrc    = 1'b1;
                mem_write = 1'b1;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                ImmSrc = IMM_B;
                branch = 1'b1;
                alu_op = ALUOP_SUB;
            end
            OP_ITYPE: begin
                reg_write = 1'b1;
                ALUSrc    = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write = 1'b1;
                ImmSrc    = IMM_J;
                ResultSrc = RES_PC4;
                jump      = 1'b1;
            end
            default: ;
        endcase
    end

    assign RegWrite = reg_write & ~rst;
    assign MemWrite = mem_write & ~rst;
    assign PCSrc    = ((branch & Zero) | jump) & ~rst;

    alu_dec u_alu_dec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl)
    );

`ifdef CTRL_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (!is_legal_op(op)) begin
            illegal_q <= 1'b1;
        end
    end

    assign Illegal = illegal_q;
`else
    // Clock only feeds the optional flag; keep it visibly consumed when the flag is off.
    logic unused_clk;
    assign unused_clk = clk;
    assign Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl.sv
// Directed self-checking bench for ctrl; Illegal expectations follow whether CTRL_ILLEGAL_EN is defined.
module tb_ctrl;

`ifdef CTRL_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       PCSrc;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic       Illegal;

    int n_assert = 0;
    int n_fail   = 0;

    ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
        .PCSrc      (PCSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z);
        @(negedge clk);
        rst = r; op = o; funct3 = f3; funct7 = f7; Zero = z;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000000; funct3 = 3'b000; funct7 = 1'b0; Zero = 1'b0;
        edge_wait();
        check("reset_illegal", {7'd0, Illegal}, 8'd0);

        // During reset: write/redirect strobes masked, other fields follow op.
        drive(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0);
        check("rst_lw_regwrite", {7'd0, RegWrite}, 8'd0);
        check("rst_lw_resultsrc", {6'd0, ResultSrc}, 8'd1);
        check("rst_lw_alusrc", {7'd0, ALUSrc}, 8'd1);
        drive(1'b1, 7'b0100011, 3'b000, 1'b0, 1'b0);
        check("rst_sw_memwrite", {7'd0, MemWrite}, 8'd0);
        check("rst_sw_immsrc", {6'd0, ImmSrc}, 8'd1);
        drive(1'b1, 7'b1101111, 3'b000, 1'b0, 1'b0);
        check("rst_jal_pcsrc", {7'd0, PCSrc}, 8'd0);
        check("rst_jal_immsrc", {6'd0, ImmSrc}, 8'd3);

        // lw
        drive(1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0);
        check("lw_regwrite", {7'd0, RegWrite}, 8'd1);
        check("lw_immsrc", {6'd0, ImmSrc}, 8'd0);
        check("lw_alusrc", {7'd0, ALUSrc}, 8'd1);
        check("lw_memwrite", {7'd0, MemWrite}, 8'd0);
        check("lw_resultsrc", {6'd0, ResultSrc}, 8'd1);
        check("lw_pcsrc", {7'd0, PCSrc}, 8'd0);
        check("lw_aluctl", {5'd0, ALUControl}, 8'd0);

        // sw
        drive(1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0);
        check("sw_regwrite", {7'd0, RegWrite}, 8'd0);
        check("sw_immsrc", {6'd0, ImmSrc}, 8'd1);
        check("sw_alusrc", {7'd0, ALUSrc}, 8'd1);
        check("sw_memwrite", {7'd0, MemWrite}, 8'd1);
        check("sw_pcsrc", {7'd0, PCSrc}, 8'd0);
        check("sw_aluctl", {5'd0, ALUControl}, 8'd0);

        // beq taken / not taken
        drive(1'b0, 7'b1100011, 3'b000, 1'b0, 1'b1);
        check("beq_z1_pcsrc", {7'd0, PCSrc}, 8'd1);
        check("beq_immsrc", {6'd0, ImmSrc}, 8'd2);
        check("beq_alusrc", {7'd0, ALUSrc}, 8'd0);
        check("beq_aluctl", {5'd0, ALUControl}, 8'd1);
        check("beq_regwrite", {7'd0, RegWrite}, 8'd0);
        drive(1'b0, 7'b1100011, 3'b000, 1'b0, 1'b0);
        check("beq_z0_pcsrc", {7'd0, PCSrc}, 8'd0);

        // jal
        drive(1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0);
        check("jal_regwrite", {7'd0, RegWrite}, 8'd1);
        check("jal_immsrc", {6'd0, ImmSrc}, 8'd3);
        check("jal_memwrite", {7'd0, MemWrite}, 8'd0);
        check("jal_resultsrc", {6'd0, ResultSrc}, 8'd2);
        check("jal_pcsrc", {7'd0, PCSrc}, 8'd1);
        check("jal_aluctl", {5'd0, ALUControl}, 8'd0);

        // ALU control decode
        drive(1'b0, 7'b0010011, 3'b000, 1'b1, 1'b0);
        check("addi_f7_aluctl", {5'd0, ALUControl}, 8'd0);
        check("addi_resultsrc", {6'd0, ResultSrc}, 8'd0);
        check("addi_alusrc", {7'd0, ALUSrc}, 8'd1);
        drive(1'b0, 7'b0110011, 3'b000, 1'b1, 1'b0);
        check("sub_aluctl", {5'd0, ALUControl}, 8'd1);
        check("r_alusrc", {7'd0, ALUSrc}, 8'd0);
        drive(1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0);
        check("add_aluctl", {5'd0, ALUControl}, 8'd0);
        drive(1'b0, 7'b0110011, 3'b111, 1'b0, 1'b0);
        check("and_aluctl", {5'd0, ALUControl}, 8'd2);
        drive(1'b0, 7'b0110011, 3'b110, 1'b0, 1'b0);
        check("or_aluctl", {5'd0, ALUControl}, 8'd3);
        drive(1'b0, 7'b0110011, 3'b010, 1'b0, 1'b0);
        check("slt_aluctl", {5'd0, ALUControl}, 8'd5);
        drive(1'b0, 7'b0110011, 3'b001, 1'b1, 1'b0);
        check("f3_001_aluctl", {5'd0, ALUControl}, 8'd0);
        drive(1'b0, 7'b0010011, 3'b111, 1'b0, 1'b0);
        check("andi_aluctl", {5'd0, ALUControl}, 8'd2);
        check("no_illegal_yet", {7'd0, Illegal}, 8'd0);

        // Unsupported opcode: every field zero, sticky flag when enabled.
        drive(1'b0, 7'b1111111, 3'b110, 1'b1, 1'b1);
        check("bad_regwrite", {7'd0, RegWrite}, 8'd0);
        check("bad_memwrite", {7'd0, MemWrite}, 8'd0);
        check("bad_pcsrc", {7'd0, PCSrc}, 8'd0);
        check("bad_alusrc", {7'd0, ALUSrc}, 8'd0);
        check("bad_immsrc", {6'd0, ImmSrc}, 8'd0);
        check("bad_resultsrc", {6'd0, ResultSrc}, 8'd0);
        check("bad_aluctl", {5'd0, ALUControl}, 8'd0);
        edge_wait();
        check("illegal_set", {7'd0, Illegal}, {7'd0, ILL_EN});
        drive(1'b0, 7'b0000011, 3'b000, 1'b0, 1'b0);
        edge_wait();
        check("illegal_held", {7'd0, Illegal}, {7'd0, ILL_EN});
        edge_wait();
        check("illegal_held2", {7'd0, Illegal}, {7'd0, ILL_EN});

        drive(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0);
        edge_wait();
        check("illegal_cleared", {7'd0, Illegal}, 8'd0);

        // Reset wins over an illegal opcode on the same edge.
        drive(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b1);
        check("rst_bad_regwrite", {7'd0, RegWrite}, 8'd0);
        check("rst_bad_memwrite", {7'd0, MemWrite}, 8'd0);
        check("rst_bad_pcsrc", {7'd0, PCSrc}, 8'd0);
        edge_wait();
        check("rst_wins", {7'd0, Illegal}, 8'd0);

        drive(1'b0, 7'b0000011, 3'b000, 1'b0, 1'b0);
        edge_wait();
        check("post_rst_clear", {7'd0, Illegal}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
